// File: rtl/munoc_lpixm_slave_arbiter.sv
// munoc_lpixm_slave_arbiter
//
// Shares one LPIXM slave port (slxq request / slxy response) between
// NUM_REQUESTER local LPIXM masters. Requests are arbitrated per burst,
// the requester index of every issued burst is queued in an outstanding
// FIFO, and in-order slave responses are steered back to the FIFO head.
//
// Optional build macro:
//   MUNOC_LPIXM_ARB_FIXED_PRIORITY_EN - when defined, IDLE always grants the
//   lowest-indexed valid requester instead of rotating round-robin.

module munoc_lpixm_slave_arbiter #(
  parameter int NUM_REQUESTER   = 2,
  parameter int BW_QDATA        = 128,
  parameter int BW_YDATA        = 64,
  parameter int NUM_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rstnn,

  // requester side
  output logic [2*NUM_REQUESTER-1:0]        rq_dready,
  input  logic [NUM_REQUESTER-1:0]          rq_valid,
  input  logic [NUM_REQUESTER-1:0]          rq_last,
  input  logic [NUM_REQUESTER*BW_QDATA-1:0] rq_data,
  input  logic [2*NUM_REQUESTER-1:0]        ry_dready,
  output logic [NUM_REQUESTER-1:0]          ry_valid,
  output logic                              ry_last,
  output logic [BW_YDATA-1:0]               ry_data,

  // slave side
  input  logic [1:0]                        sq_dready,
  output logic                              sq_valid,
  output logic                              sq_last,
  output logic [BW_QDATA-1:0]               sq_data,
  output logic [1:0]                        sy_dready,
  input  logic                              sy_valid,
  input  logic                              sy_last,
  input  logic [BW_YDATA-1:0]               sy_data,

  output logic                              busy
);

  // grant index width (1 bit for two requesters, 2 bits for three or four)
  localparam int GW = (NUM_REQUESTER > 2) ? 2 : 1;
  // FIFO pointer width and occupancy counter width (0..NUM_OUTSTANDING)
  localparam int PW = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   winner;
  logic            any_valid;
  logic            take_grant;
  logic            push;
  logic            pop;

`ifndef MUNOC_LPIXM_ARB_FIXED_PRIORITY_EN
  logic [GW-1:0]   last_grant;
`endif

  logic [GW-1:0]   fifo_mem [NUM_OUTSTANDING];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [GW-1:0]   head;

  assign any_valid  = |rq_valid;
  assign fifo_full  = (count == CW'(NUM_OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];

`ifdef MUNOC_LPIXM_ARB_FIXED_PRIORITY_EN
  // Fixed priority: scan downward so the lowest valid index is written last.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQUESTER - 1; i >= 0; i--) begin
      if (rq_valid[i]) begin
        winner = GW'(i);
      end
    end
  end
`else
  // Round-robin: search from last_grant+1, wrapping, first valid requester wins.
  always_comb begin
    int  idx;
    logic found;
    winner = last_grant;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQUESTER; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQUESTER) begin
        idx = idx - NUM_REQUESTER;
      end
      if (!found && rq_valid[idx]) begin
        winner = GW'(idx);
        found  = 1'b1;
      end
    end
  end
`endif

  // Request mux: the granted requester drives the slave port only while in BURST.
  always_comb begin
    sq_valid  = 1'b0;
    sq_last   = 1'b0;
    sq_data   = '0;
    rq_dready = '0;
    for (int i = 0; i < NUM_REQUESTER; i++) begin
      if (grant == GW'(i)) begin
        sq_data = rq_data[i*BW_QDATA +: BW_QDATA];
        if (state == BURST) begin
          sq_valid              = rq_valid[i];
          sq_last               = rq_last[i];
          rq_dready[2*i +: 2]   = sq_dready;
        end
      end
    end
  end

  // Next-state logic: grant from IDLE only when the FIFO has room, so a burst
  // in progress can always push its index on the last beat.
  always_comb begin
    state_next = state;
    take_grant = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid && !fifo_full) begin
          take_grant = 1'b1;
          state_next = BURST;
        end
      end
      BURST: begin
        if (sq_valid && sq_dready[0] && sq_last) begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant register; the burst stays locked to this index until its last beat.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      grant <= '0;
    end else if (take_grant) begin
      grant <= winner;
    end
  end

`ifndef MUNOC_LPIXM_ARB_FIXED_PRIORITY_EN
  // Round-robin history; resets to the top index so requester 0 wins first.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      last_grant <= GW'(NUM_REQUESTER - 1);
    end else if (take_grant) begin
      last_grant <= winner;
    end
  end
`endif

  // Response steering: the FIFO head owns the response channel; stall when empty.
  always_comb begin
    ry_valid  = '0;
    sy_dready = '0;
    if (!fifo_empty) begin
      for (int i = 0; i < NUM_REQUESTER; i++) begin
        if (head == GW'(i)) begin
          ry_valid[i] = sy_valid;
          sy_dready   = ry_dready[2*i +: 2];
        end
      end
    end
  end

  assign pop     = !fifo_empty && sy_valid && sy_dready[0] && sy_last;
  assign ry_last = sy_last;
  assign ry_data = sy_data;
  assign busy    = (state != IDLE) || !fifo_empty;

  // Outstanding-burst FIFO storage and write pointer.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      for (int i = 0; i < NUM_OUTSTANDING; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (push) begin
      fifo_mem[wr_ptr] <= grant;
      wr_ptr           <= wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on the last response beat of each burst.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy counter; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
